btn_event_decoder: RTL

Sits directly downstream of the push-button debounce stage, on the same `clk`. It takes the clean, debounced button level and classifies each press into one of four one-cycle event pulses: single click, double click, long press, and auto-repeat while held. UI/control logic consumes these pulses instead of raw button edges.

---
 rtl/btn_event_decoder.sv | 86 ++++++++
 1 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies debounced button presses into click, double click, long press and repeat pulses
module btn_event_decoder #(
  parameter int TICK_DIV     = 100,
  parameter int LONG_TICKS   = 50,
  parameter int DCLICK_TICKS = 25,
  parameter int REPEAT_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic key_rpt,
  output logic busy
);
  localparam int M1   = LONG_TICKS > DCLICK_TICKS ? LONG_TICKS : DCLICK_TICKS;
  localparam int MAXT = M1 > REPEAT_TICKS ? M1 : REPEAT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int PW   = $clog2(TICK_DIV + 1);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0] evt_q, evt_d;
  logic btn_q, btn_d, busy_q, busy_d;
  logic tick, rise, fall, to_long, to_dc, to_rpt, restart;
  assign tick    = pre_q == PW'(TICK_DIV - 1);
  assign rise    = btn_in & ~btn_q;
  assign fall    = ~btn_in & btn_q;
  assign to_long = tick && cnt_q == CW'(LONG_TICKS - 1);
  assign to_dc   = tick && cnt_q == CW'(DCLICK_TICKS - 1);
  assign to_rpt  = tick && cnt_q == CW'(REPEAT_TICKS - 1);
  assign {key_rpt, long_press, dclick, click} = evt_q;
  assign busy = busy_q;
  // next state, event decode, prescaler and per-state tick counter
  always_comb begin
    state_d = state_q;
    evt_d   = '0;
    restart = 1'b0;
    btn_d   = btn_in;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    case (state_q)
      IDLE:      if (rise) state_d = PRESS1;
      PRESS1:    if (to_long) begin
                   state_d = LONG_HOLD;
                   evt_d   = 4'b0100;
                 end else if (fall) state_d = WAIT2;
      WAIT2:     if (rise) state_d = PRESS2;
                 else if (to_dc) begin
                   state_d = IDLE;
                   evt_d   = 4'b0001;
                 end
      PRESS2:    if (fall) begin
                   state_d = IDLE;
                   evt_d   = 4'b0010;
                 end
      LONG_HOLD: if (!btn_in) state_d = IDLE;
                 else if (to_rpt) begin
                   evt_d   = 4'b1000;
                   restart = 1'b1;
                 end
      default:   state_d = IDLE;
    endcase
    cnt_d  = (restart || state_d != state_q) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    busy_d = state_d != IDLE;
  end
  // state registers; btn_q resets high so a button held through reset is not a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      evt_q   <= '0;
      btn_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      evt_q   <= evt_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
    end
  end
endmodule
